// File: rtl/flow_frame_ctrl_if.sv
// Gradient/accumulator strobe bundle between the gradient stage, flow_frame_ctrl
// and window_accumulator.
interface flow_frame_ctrl_if;
  logic grad_valid_in;
  logic grad_ready;
  logic grad_valid_out;
  logic accum_valid;

  modport master (
    output grad_valid_in,
    output accum_valid,
    input  grad_ready,
    input  grad_valid_out
  );

  modport slave (
    input  grad_valid_in,
    input  accum_valid,
    output grad_ready,
    output grad_valid_out
  );
endinterface

// File: rtl/flow_frame_ctrl.sv
// Frame sequencer for the Lucas-Kanade structure-tensor datapath: clears the
// datapath, gates gradient pixels, counts windows and reports frame status.
module flow_frame_ctrl #(
  parameter int WIDTH         = 320,
  parameter int HEIGHT        = 240,
  parameter int WINDOW_SIZE   = 5,
  parameter int EXP_WINDOWS   = (WIDTH - WINDOW_SIZE + 1) * (HEIGHT - WINDOW_SIZE + 1),
  parameter int CLEAR_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 1024,
  localparam int WIN_W        = $clog2(EXP_WINDOWS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  flow_frame_ctrl_if.slave   gbus,
  output logic               dp_rst_n,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_cnt,
  output logic [WIN_W-1:0]   win_cnt,
  output logic               err_timeout,
  output logic               err_drop,
  output logic               err_extra
);

  localparam int PIX_TOTAL = WIDTH * HEIGHT;
  localparam int PIX_W     = $clog2(PIX_TOTAL + 1);
  localparam int DRN_W     = $clog2(DRAIN_TIMEOUT + 1);
  localparam int CLR_W     = $clog2(CLEAR_CYCLES + 1);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_TOTAL - 1);
  localparam logic [WIN_W-1:0] WIN_FULL = WIN_W'(EXP_WINDOWS);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CLR_W-1:0]   clr_q, clr_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic [WIN_W-1:0]   win_d;
  logic [15:0]        frm_d;
  logic               to_d, drop_d, extra_d;
  logic               dp_rst_d, done_d;
  logic               run;
  logic               pix_acc;

  assign run                 = (state_q == S_RUN);
  assign pix_acc             = gbus.grad_valid_in & run;
  assign gbus.grad_ready     = run;
  assign gbus.grad_valid_out = pix_acc;
  assign busy                = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    pix_d    = pix_q;
    drn_d    = drn_q;
    win_d    = win_cnt;
    frm_d    = frame_cnt;
    to_d     = err_timeout;
    drop_d   = err_drop;
    extra_d  = err_extra;
    dp_rst_d = 1'b1;
    done_d   = 1'b0;

    if (abort) begin
      // abort freezes every counter and flag; only the state and datapath reset move
      state_d  = S_IDLE;
      dp_rst_d = 1'b0;
    end else begin
      if (gbus.grad_valid_in && !run)
        drop_d = 1'b1;

      if (gbus.accum_valid && (state_q == S_RUN || state_q == S_DRAIN)) begin
        if (win_cnt == WIN_FULL)
          extra_d = 1'b1;
        else
          win_d = win_cnt + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CLEAR;
            clr_d   = '0;
            pix_d   = '0;
            drn_d   = '0;
            win_d   = '0;
            to_d    = 1'b0;
            drop_d  = 1'b0;
            extra_d = 1'b0;
          end
        end
        S_CLEAR: begin
          if (clr_q == CLR_LAST)
            state_d = S_RUN;
          else
            clr_d = clr_q + 1'b1;
        end
        S_RUN: begin
          if (pix_acc) begin
            pix_d = pix_q + 1'b1;
            if (pix_q == PIX_LAST)
              state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          drn_d = drn_q + 1'b1;
          // win_d already includes this cycle's strobe, so completion beats expiry
          if (win_d == WIN_FULL) begin
            state_d = S_DONE;
          end else if (drn_q == DRN_LAST) begin
            to_d    = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (state_d == S_CLEAR)
        dp_rst_d = 1'b0;

      if (state_q == S_DRAIN && state_d == S_DONE) begin
        done_d = 1'b1;
        frm_d  = frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clr_q       <= '0;
      pix_q       <= '0;
      drn_q       <= '0;
      win_cnt     <= '0;
      frame_cnt   <= '0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
      err_extra   <= 1'b0;
      dp_rst_n    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      pix_q       <= pix_d;
      drn_q       <= drn_d;
      win_cnt     <= win_d;
      frame_cnt   <= frm_d;
      err_timeout <= to_d;
      err_drop    <= drop_d;
      err_extra   <= extra_d;
      dp_rst_n    <= dp_rst_d;
      frame_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_flow_frame_ctrl.sv
// Randomized bench for flow_frame_ctrl; expectations come from a frame timeline
// model built from pixel/window counts and cycle offsets.
module tb_flow_frame_ctrl;
  localparam int W     = 8;
  localparam int H     = 6;
  localparam int WS    = 5;
  localparam int EXPW  = (W - WS + 1) * (H - WS + 1);
  localparam int CC    = 2;
  localparam int DT    = 16;
  localparam int NPIX  = W * H;
  localparam int WIN_W = $clog2(EXPW + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             dp_rst_n;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic             err_timeout;
  logic             err_drop;
  logic             err_extra;

  flow_frame_ctrl_if gif ();

  flow_frame_ctrl #(
    .WIDTH         (W),
    .HEIGHT        (H),
    .WINDOW_SIZE   (WS),
    .EXP_WINDOWS   (EXPW),
    .CLEAR_CYCLES  (CC),
    .DRAIN_TIMEOUT (DT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .gbus        (gif),
    .dp_rst_n    (dp_rst_n),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .win_cnt     (win_cnt),
    .err_timeout (err_timeout),
    .err_drop    (err_drop),
    .err_extra   (err_extra)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    start             = 1'b0;
    abort             = 1'b0;
    gif.grad_valid_in = 1'b0;
    gif.accum_valid   = 1'b0;
  endtask

  task automatic chk_status(input string pfx, input int e_win, input bit e_drop,
                            input bit e_extra, input bit e_to);
    chk({pfx, ".win_cnt"},     32'(win_cnt),     32'(e_win));
    chk({pfx, ".err_drop"},    32'(err_drop),    32'(e_drop));
    chk({pfx, ".err_extra"},   32'(err_extra),   32'(e_extra));
    chk({pfx, ".err_timeout"}, 32'(err_timeout), 32'(e_to));
  endtask

  // Asynchronous reset in the middle of a cycle, then release and recovery.
  task automatic reset_mid();
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    m_frames = 0;
    chk("rst.dp_rst_n",   32'(dp_rst_n),       32'(0));
    chk("rst.busy",       32'(busy),           32'(0));
    chk("rst.frame_done", 32'(frame_done),     32'(0));
    chk("rst.frame_cnt",  32'(frame_cnt),      32'(0));
    chk("rst.grad_ready", 32'(gif.grad_ready), 32'(0));
    chk_status("rst", 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst.dp_rst_hold", 32'(dp_rst_n), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.dp_rst_release", 32'(dp_rst_n), 32'(0));
    @(negedge clk); #1;
    chk("rst.dp_rst_after", 32'(dp_rst_n), 32'(1));
    chk("rst.busy_after",   32'(busy),     32'(0));
  endtask

  // One frame starting with start at local cycle 0. Negative late_off/abort_pix/rst_pix disable them.
  task automatic do_frame(input int n_win, input int late_off, input bit drop,
                          input int abort_pix, input int rst_pix);
    int c, pix, d_entry, done_cyc, m_win, k_full, sent;
    bit m_drop, m_extra, m_to, gvi, av, e_ready, active;
    pix = 0; d_entry = -1; done_cyc = -1; m_win = 0; k_full = -1; sent = 0;
    m_drop = 1'b0; m_extra = 1'b0; m_to = 1'b0;
    c = 0;
    while (done_cyc < 0 || c <= done_cyc) begin
      @(negedge clk);
      if (c > 400) begin
        chk("frame_bound", 32'(c), 32'(0));
        drive_idle();
        return;
      end
      if (rst_pix >= 0 && pix == rst_pix) begin
        reset_mid();
        return;
      end
      e_ready = (c >= CC + 1) && (d_entry < 0);
      active  = (c >= CC + 1) && (done_cyc < 0 || c < done_cyc);
      start = (c == 0);
      abort = 1'b0;
      gvi = 1'b0;
      av  = 1'b0;
      if (abort_pix >= 0 && pix == abort_pix && e_ready) begin
        abort = 1'b1;
        start = 1'b1;
      end else begin
        if (e_ready)
          gvi = ($urandom_range(0, 3) != 0);
        else if (drop && (c == 1 || c == d_entry))
          gvi = 1'b1;
        if (active && sent < n_win && (d_entry >= 0 || $urandom_range(0, 1) == 1)) begin
          av = 1'b1;
          sent++;
        end
        if (late_off >= 0 && d_entry >= 0 && c == d_entry + late_off)
          av = 1'b1;
      end
      gif.grad_valid_in = gvi;
      gif.accum_valid   = av;
      #1;
      chk("dp_rst_n",       32'(dp_rst_n),           32'(!(c >= 1 && c <= CC)));
      chk("grad_ready",     32'(gif.grad_ready),     32'(e_ready));
      chk("grad_valid_out", 32'(gif.grad_valid_out), 32'(gvi & e_ready));
      chk("busy",           32'(busy),               32'(c >= 1));
      chk("frame_done",     32'(frame_done),         32'(done_cyc >= 0 && c == done_cyc));
      if (c >= 1)
        chk_status("cyc", m_win, m_drop, m_extra, m_to);
      if (abort) begin
        @(negedge clk);
        drive_idle();
        #1;
        chk("abort.busy",       32'(busy),           32'(0));
        chk("abort.dp_rst_n",   32'(dp_rst_n),       32'(0));
        chk("abort.frame_done", 32'(frame_done),     32'(0));
        chk("abort.grad_ready", 32'(gif.grad_ready), 32'(0));
        chk("abort.frame_cnt",  32'(frame_cnt),      32'(m_frames));
        chk_status("abort", m_win, m_drop, m_extra, m_to);
        @(negedge clk); #1;
        chk("abort.dp_rst_after", 32'(dp_rst_n), 32'(1));
        chk("abort.busy_after",   32'(busy),     32'(0));
        return;
      end
      if (gvi && !e_ready) m_drop = 1'b1;
      if (gvi && e_ready) begin
        pix++;
        if (pix == NPIX) d_entry = c + 1;
      end
      if (av && active) begin
        if (m_win == EXPW) m_extra = 1'b1;
        else begin
          m_win++;
          if (m_win == EXPW) k_full = c;
        end
      end
      if (done_cyc < 0 && d_entry >= 0 && c >= d_entry) begin
        if (k_full >= 0) done_cyc = c + 1;
        else if (c == d_entry + DT - 1) begin
          done_cyc = c + 1;
          m_to = 1'b1;
        end
      end
      c++;
    end
    m_frames = (m_frames + 1) % 65536;
    @(negedge clk);
    drive_idle();
    #1;
    chk("end.busy",       32'(busy),       32'(0));
    chk("end.frame_done", 32'(frame_done), 32'(0));
    chk("end.dp_rst_n",   32'(dp_rst_n),   32'(1));
    chk("end.frame_cnt",  32'(frame_cnt),  32'(m_frames));
    chk_status("end", m_win, m_drop, m_extra, m_to);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk); #1;
    chk("init.dp_rst_n",   32'(dp_rst_n),   32'(0));
    chk("init.busy",       32'(busy),       32'(0));
    chk("init.frame_done", 32'(frame_done), 32'(0));
    chk("init.frame_cnt",  32'(frame_cnt),  32'(0));
    chk_status("init", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      chk("idle.dp_rst_n", 32'(dp_rst_n), 32'(1));
    end

    do_frame(8, -1, 1'b0, -1, -1);    // nominal
    do_frame(5, -1, 1'b0, -1, -1);    // timeout
    do_frame(9, -1, 1'b1, -1, -1);    // drop + extra
    do_frame(8, -1, 1'b0, 30, -1);    // abort with start after 30 pixels
    do_frame(8, -1, 1'b0, -1, -1);    // clean frame after abort
    do_frame(7, DT - 1, 1'b0, -1, -1); // final window on the expiry cycle
    do_frame(8, -1, 1'b0, -1, 20);    // reset after 20 pixels
    do_frame(8, -1, 1'b0, -1, -1);
    for (int unsigned i = 0; i < 4; i++)
      do_frame(int'($urandom_range(5, 9)), -1, 1'($urandom_range(0, 1)), -1, -1);

    @(negedge clk);
    dut.frame_cnt <= 16'hFFFF;
    m_frames = 65535;
    @(negedge clk); #1;
    chk("preload.frame_cnt", 32'(frame_cnt), 32'(65535));
    do_frame(8, -1, 1'b0, -1, -1);
    chk("wrap.frame_cnt", 32'(frame_cnt), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flow_frame_ctrl.md
# flow_frame_ctrl

Frame-level sequencer for the Lucas-Kanade structure-tensor datapath. It clears the gradient line buffers and window accumulator before each frame and gates the gradient pixel stream into them. It counts accepted pixels and emitted windows, and signals frame completion or failure to the host control logic. It sits between the gradient stage and `window_accumulator`, and owns that block's reset and `grad_valid` input.

## Interface
Parameters:
- `WIDTH`, 320, frame width in pixels
- `HEIGHT`, 240, frame height in pixels
- `WINDOW_SIZE`, 5, accumulator window edge
- `EXP_WINDOWS`, (WIDTH-WINDOW_SIZE+1)*(HEIGHT-WINDOW_SIZE+1), windows expected per frame
- `CLEAR_CYCLES`, 2, cycles `dp_rst_n` is held low per frame
- `DRAIN_TIMEOUT`, 1024, maximum cycles in DRAIN

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a frame; sampled in IDLE only
- `abort`  in  1  cancel the current frame; highest priority
- `grad_valid_in`  in  1  pixel strobe from the gradient stage
- `grad_ready`  out  1  high only in RUN
- `grad_valid_out`  out  1  `grad_valid_in & grad_ready`, combinational, drives the accumulator
- `accum_valid`  in  1  window strobe from the accumulator
- `dp_rst_n`  out  1  registered datapath reset, active-low
- `busy`  out  1  state != IDLE
- `frame_done`  out  1  one-cycle pulse in DONE
- `frame_cnt`  out  16  completed frames, including timed-out frames; wraps at 65535 -> 0
- `win_cnt`  out  $clog2(EXP_WINDOWS+1)  windows counted in the current frame
- `err_timeout`, `err_drop`, `err_extra`  out  1 each  sticky status flags

## Operation
- The FSM has five states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE -> CLEAR on `start`. On this transition:
  - clear `win_cnt`, the pixel counter, the drain counter, and all three error flags.
- CLEAR:
  - `dp_rst_n` = 0 for exactly CLEAR_CYCLES cycles, then state -> RUN.
- RUN:
  - each `grad_valid_out` increments the pixel counter (width $clog2(WIDTH*HEIGHT+1)).
  - the pixel that brings the count to WIDTH*HEIGHT moves the state to DRAIN.
- DRAIN:
  - `grad_ready` = 0.
  - the drain counter increments every cycle.
  - `win_cnt` reaching EXP_WINDOWS moves the state to DONE.
  - the drain counter reaching DRAIN_TIMEOUT-1 without completion sets `err_timeout` and moves the state to DONE.
- DONE: `frame_done` = 1 and `frame_cnt` increments. Next state is IDLE.
- Window counting: `accum_valid` increments `win_cnt` in RUN and DRAIN only.
  - `win_cnt` saturates at EXP_WINDOWS.
  - `accum_valid` arriving while `win_cnt` == EXP_WINDOWS sets `err_extra`.
  - `accum_valid` in IDLE, CLEAR or DONE is ignored.
- Drop detection: `grad_valid_in` while not in RUN sets `err_drop`. The pixel is not forwarded.
- `start` outside IDLE is ignored and has no side effects.
- Abort: `abort` in any state moves the state to IDLE next cycle.
  - no `frame_done` pulse, and `frame_cnt` is unchanged.
  - counters and flags hold their values.
  - `dp_rst_n` is driven low for that one transition cycle.
- Simultaneous events:
  - `abort` and `start` in the same cycle: abort wins, state stays IDLE.
  - final window and timeout expiry in the same cycle: completion wins, `err_timeout` stays 0.
  - last pixel in RUN and `accum_valid` in the same cycle: both are counted.
- Reset (`rst_n` = 0), asynchronous, at any time including mid-frame, forces:
  - state IDLE.
  - `dp_rst_n` = 0 while `rst_n` is low; it goes to 1 on the first clock edge after release.
  - all counters 0, all flags 0, `frame_done` 0.

## Timing
- `start` high in IDLE at cycle N:
  - CLEAR during N+1 .. N+CLEAR_CYCLES, with `dp_rst_n` low over the same cycles.
  - RUN from N+CLEAR_CYCLES+1; `grad_ready` goes high that cycle.
- Last pixel accepted at cycle M: DRAIN at M+1, and `grad_ready` = 0 at M+1.
- `accum_valid` that completes `win_cnt` at cycle K: `frame_done` = 1 at K+1 only; IDLE at K+2, where `start` is sampled again.
- Timeout: if DRAIN is entered at D with no completion, DONE occurs at D+DRAIN_TIMEOUT.
- `grad_valid_out` and `grad_ready` have zero latency, decoded from the state register. All other outputs are registered.
- Flags and `win_cnt` update one cycle after the causing event.

## Test plan
Use WIDTH=8, HEIGHT=6, WINDOW_SIZE=5 (EXP_WINDOWS=8, 48 pixels per frame), CLEAR_CYCLES=2, DRAIN_TIMEOUT=16 for all scenarios.
- Reset mid-RUN after 20 pixels -> all outputs 0 except `dp_rst_n`. `dp_rst_n` is 0 during reset and 1 one cycle after release. The state is IDLE. A following `start` runs a clean frame.
- Nominal frame:
  - stimulus: `start` at cycle 10, then 48 pixels, then 8 `accum_valid` strobes.
  - `dp_rst_n` is low at cycles 11-12 and `grad_ready` is high at 13.
  - exactly one `frame_done`, `frame_cnt` = 1, `win_cnt` = 8, all flags 0.
- Timeout: 48 pixels but only 5 windows -> DONE 16 cycles after DRAIN entry. `err_timeout` = 1, `win_cnt` = 5, `frame_cnt` increments.
- Drop and extra:
  - `grad_valid_in` pulses during CLEAR and DRAIN -> `err_drop` = 1, and `grad_valid_out` stays 0 throughout.
  - a 9th `accum_valid` before DONE -> `err_extra` = 1, `win_cnt` stays 8.
- Abort:
  - `abort` plus `start` in RUN after 30 pixels -> IDLE next cycle, no `frame_done`, `frame_cnt` unchanged, `dp_rst_n` low for one cycle.
  - a subsequent `start` clears the counters.
- Boundary: final `accum_valid` in the same cycle as timeout expiry -> `frame_done` with `err_timeout` = 0.
- `frame_cnt` wrap: preload to 65535 -> after one frame, reads 0.
